// File: rtl/uart_rx_byte_if.sv
// Received-byte valid/ready channel between the UART receiver and its consumer.
// master drives m_data/m_valid, slave returns m_ready.
interface uart_rx_byte_if;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready;

  modport master (
    output m_data,
    output m_valid,
    input  m_ready
  );

  modport slave (
    input  m_data,
    input  m_valid,
    output m_ready
  );
endinterface

// File: rtl/uart_rx_byte.sv
// UART byte receiver (8N1, or 8E1 with UART_RX_PARITY_EN) with a one-deep valid/ready output buffer.
// Latency: start edge to START 3 cycles; stop mid-sample to m_valid 2 cycles.
// Backpressure: a full buffer with m_ready low keeps the old byte, drops the new one and pulses rx_overrun.
module uart_rx_byte #(
  parameter int CLK_HZ = 100_000_000,
  parameter int BAUD   = 115_200
) (
  input  logic           clk_100mhz,
  input  logic           sys_rst,
  input  logic           uart_rxd,
  uart_rx_byte_if.master byte_if,
  output logic           rx_frame_err,
  output logic           rx_overrun,
  output logic           rx_parity_err
);

  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int HALF         = CLKS_PER_BIT / 2;
  localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_BRK
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;
  logic             rx_meta;
  logic             rxs;
  logic             frame_done;
`ifdef UART_RX_PARITY_EN
  logic             par_bad;
`else
  assign rx_parity_err = 1'b0;
`endif

  always_ff @(posedge clk_100mhz) begin
    if (sys_rst) begin
      state           <= S_IDLE;
      cnt             <= '0;
      bit_idx         <= '0;
      shreg           <= '0;
      rx_meta         <= 1'b1;
      rxs             <= 1'b1;
      frame_done      <= 1'b0;
      rx_frame_err    <= 1'b0;
      rx_overrun      <= 1'b0;
      byte_if.m_data  <= '0;
      byte_if.m_valid <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad         <= 1'b0;
      rx_parity_err   <= 1'b0;
`endif
    end else begin
      rx_meta      <= uart_rxd;
      rxs          <= rx_meta;
      frame_done   <= 1'b0;
      rx_frame_err <= 1'b0;
      rx_overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      rx_parity_err <= 1'b0;
`endif

      case (state)
        S_IDLE: begin
          if (!rxs) begin
            state <= S_START;
            cnt   <= '0;
          end
        end

        // Mid-start re-check rejects glitches shorter than half a bit.
        S_START: begin
          if (cnt == CNT_HALF) begin
            cnt <= '0;
            if (rxs) begin
              state <= S_IDLE;
            end else begin
              state   <= S_DATA;
              bit_idx <= '0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_DATA: begin
          if (cnt == CNT_FULL) begin
            cnt     <= '0;
            shreg   <= {rxs, shreg[7:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= S_PARITY;
`else
              state <= S_STOP;
`endif
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

`ifdef UART_RX_PARITY_EN
        // Even parity: the parity bit must equal the XOR of the data bits.
        S_PARITY: begin
          if (cnt == CNT_FULL) begin
            cnt     <= '0;
            par_bad <= rxs ^ (^shreg);
            state   <= S_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`endif

        S_STOP: begin
          if (cnt == CNT_FULL) begin
            cnt <= '0;
            if (rxs) begin
              state <= S_IDLE;
`ifdef UART_RX_PARITY_EN
              if (par_bad) rx_parity_err <= 1'b1;
              else         frame_done    <= 1'b1;
`else
              frame_done <= 1'b1;
`endif
            end else begin
              rx_frame_err <= 1'b1;
              state        <= S_BRK;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_BRK: begin
          if (rxs) begin
            state <= S_IDLE;
            cnt   <= '0;
          end
        end

        default: begin
          state <= S_IDLE;
          cnt   <= '0;
        end
      endcase

      // A consumer accepting in the completion cycle frees the slot for the new byte.
      if (frame_done) begin
        if (!byte_if.m_valid) begin
          byte_if.m_data  <= shreg;
          byte_if.m_valid <= 1'b1;
        end else if (byte_if.m_ready) begin
          byte_if.m_data <= shreg;
        end else begin
          rx_overrun <= 1'b1;
        end
      end else if (byte_if.m_valid && byte_if.m_ready) begin
        byte_if.m_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_byte.sv
// Randomized scoreboard bench for uart_rx_byte at 10 clocks per bit; parity frames when UART_RX_PARITY_EN is defined.
module tb_uart_rx_byte;
  localparam int BIT = 10;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic sys_rst;
  logic uart_rxd;
  logic rx_frame_err, rx_overrun, rx_parity_err;

  uart_rx_byte_if bif ();

  uart_rx_byte #(.CLK_HZ(100_000_000), .BAUD(10_000_000)) dut (
    .clk_100mhz   (clk),
    .sys_rst      (sys_rst),
    .uart_rxd     (uart_rxd),
    .byte_if      (bif.master),
    .rx_frame_err (rx_frame_err),
    .rx_overrun   (rx_overrun),
    .rx_parity_err(rx_parity_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] exp_q[$];
  int  exp_frame = 0, exp_ovr = 0, exp_par = 0;
  int  obs_frame = 0, obs_ovr = 0, obs_par = 0;
  bit  model_full = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: pops the scoreboard on every accepted byte and counts error pulses.
  logic [7:0] prev_data;
  bit         prev_stall = 1'b0;
  always @(negedge clk) begin
    if (sys_rst) begin
      prev_stall = 1'b0;
    end else begin
      obs_frame += int'(rx_frame_err);
      obs_ovr   += int'(rx_overrun);
      obs_par   += int'(rx_parity_err);
      if (prev_stall && bif.m_valid)
        check("hold_stable", 32'(bif.m_data), 32'(prev_data));
      if (bif.m_valid && bif.m_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_byte: got 0x%0h, expected no byte", bif.m_data);
        end else begin
          check("rx_byte", 32'(bif.m_data), 32'(exp_q.pop_front()));
        end
      end
      prev_stall = bif.m_valid && !bif.m_ready;
      prev_data  = bif.m_data;
    end
  end

  task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_ok);
    uart_rxd = 1'b0;
    wait_clks(BIT);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = d[i];
      wait_clks(BIT);
    end
    if (PAR_EN) begin
      uart_rxd = (^d) ^ !par_ok;
      wait_clks(BIT);
    end
    uart_rxd = stop_b;
    wait_clks(BIT);
  endtask

  // Reference model: a frame's fate follows only from stop bit, parity and buffer occupancy.
  task automatic issue(input logic [7:0] d, input logic stop_ok, input logic par_ok);
    bit good;
    good = stop_ok && (par_ok || !PAR_EN);
    if (!stop_ok) exp_frame++;
    else if (!good) exp_par++;
    if (good) begin
      if (bif.m_ready) exp_q.push_back(d);
      else if (!model_full) begin
        exp_q.push_back(d);
        model_full = 1'b1;
      end else exp_ovr++;
    end
    send_frame(d, stop_ok, par_ok);
  endtask

  task automatic set_ready(input logic r);
    bif.m_ready = r;
    if (r) model_full = 1'b0;
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_frame_err"}, 32'(obs_frame), 32'(exp_frame));
    check({tag, "_overrun"},   32'(obs_ovr),   32'(exp_ovr));
    check({tag, "_parity_err"},32'(obs_par),   32'(exp_par));
  endtask

  task automatic check_idle_outputs(input string tag, input logic [7:0] data_exp);
    check({tag, "_m_valid"},   32'(bif.m_valid),   32'(0));
    check({tag, "_m_data"},    32'(bif.m_data),    32'(data_exp));
    check({tag, "_frame_err"}, 32'(rx_frame_err),  32'(0));
    check({tag, "_overrun"},   32'(rx_overrun),    32'(0));
    check({tag, "_parity_err"},32'(rx_parity_err), 32'(0));
  endtask

  initial begin
    sys_rst     = 1'b1;
    uart_rxd    = 1'b1;
    bif.m_ready = 1'b1;
    wait_clks(3);
    sys_rst = 1'b0;
    check_idle_outputs("reset", 8'h00);
    wait_clks(5);

    // Basic frame with consumer ready.
    issue(8'hA5, 1'b1, 1'b1);
    wait_clks(20);
    check_counts("t1");
    check("t1_queue_empty", 32'(exp_q.size()), 32'(0));

    // Short low glitch must be rejected silently.
    uart_rxd = 1'b0;
    wait_clks(3);
    uart_rxd = 1'b1;
    wait_clks(30);
    check_counts("t2");
    check("t2_m_valid", 32'(bif.m_valid), 32'(0));

    // Bad stop bit, line held low, then a clean frame.
    issue(8'h3C, 1'b0, 1'b1);
    uart_rxd = 1'b0;
    wait_clks(50);
    check("t3_m_valid_low", 32'(bif.m_valid), 32'(0));
    uart_rxd = 1'b1;
    wait_clks(15);
    issue(8'h81, 1'b1, 1'b1);
    wait_clks(20);
    check_counts("t3");
    check("t3_queue_empty", 32'(exp_q.size()), 32'(0));

    // Overrun: consumer stalled across two back-to-back frames.
    set_ready(1'b0);
    wait_clks(5);
    issue(8'h11, 1'b1, 1'b1);
    issue(8'h22, 1'b1, 1'b1);
    wait_clks(20);
    check("t4_m_valid", 32'(bif.m_valid), 32'(1));
    check("t4_m_data",  32'(bif.m_data),  32'(8'h11));
    check_counts("t4");
    set_ready(1'b1);
    wait_clks(3);
    check("t4_m_valid_fall", 32'(bif.m_valid), 32'(0));
    check("t4_queue_empty", 32'(exp_q.size()), 32'(0));

    // Reset in the middle of a frame.
    uart_rxd = 1'b0;
    wait_clks(BIT);
    uart_rxd = 1'b1;
    wait_clks(4 * BIT);
    sys_rst = 1'b1;
    wait_clks(2);
    sys_rst = 1'b0;
    check_idle_outputs("t5_rst", 8'h00);
    wait_clks(6 * BIT);
    issue(8'h5A, 1'b1, 1'b1);
    wait_clks(20);
    check_counts("t5");
    check("t5_queue_empty", 32'(exp_q.size()), 32'(0));

`ifdef UART_RX_PARITY_EN
    issue(8'h07, 1'b1, 1'b1);
    wait_clks(5);
    issue(8'h07, 1'b1, 1'b0);
    wait_clks(20);
    check_counts("t6");
    check("t6_queue_empty", 32'(exp_q.size()), 32'(0));
`endif

    // Randomized traffic: bytes, gaps, bad stops, parity errors and stalls.
    for (int n = 0; n < 30; n++) begin
      logic [7:0] d;
      logic       stop_ok, par_ok;
      d       = 8'($urandom);
      stop_ok = ($urandom_range(0, 7) != 0);
      par_ok  = PAR_EN ? ($urandom_range(0, 5) != 0) : 1'b1;
      if ($urandom_range(0, 3) == 0) begin
        wait_clks(5);
        set_ready(!bif.m_ready);
      end
      issue(d, stop_ok, par_ok);
      if (!stop_ok) begin
        uart_rxd = 1'b0;
        wait_clks($urandom_range(0, 30));
        uart_rxd = 1'b1;
        wait_clks(15);
      end else begin
        wait_clks($urandom_range(0, 8));
      end
    end
    wait_clks(5);
    set_ready(1'b1);

    begin
      int budget;
      budget = 200;
      while (exp_q.size() != 0 && budget > 0) begin
        wait_clks(1);
        budget--;
      end
    end
    wait_clks(20);
    check("rand_drain", 32'(exp_q.size()), 32'(0));
    check_counts("rand");
    check("final_m_valid", 32'(bif.m_valid), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
